// File: rtl/multicycle_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_pkg
// Shared definitions for the multi-cycle CPU control unit:
//   - FSM state encoding (IF is encoded as 0 so a forced-zero debug bus reads IF)
//   - 6-bit instruction opcodes
//   - ALUOp operation codes
//   - PCSrc selector codes
// ----------------------------------------------------------------------------
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_R  = 4'd2,
        S_EXE_LS = 4'd3,
        S_EXE_B  = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_R   = 4'd7,
        S_WB_LD  = 4'd8,
        S_HALT   = 4'd9
    } state_e;

    // Instruction opcodes
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b110;

    // Next-PC source selectors
    localparam logic [1:0] PC_SEQ    = 2'b00;  // PC + 4
    localparam logic [1:0] PC_BRANCH = 2'b01;  // branch target
    localparam logic [1:0] PC_JUMP   = 2'b10;  // jump target

endpackage

// File: rtl/alu_op_decode.sv
// ----------------------------------------------------------------------------
// alu_op_decode
// Purely combinational decode of the latched opcode into datapath controls.
// Ports:
//   i_op_q      [OP_W-1:0] opcode latched at the end of ID
//   o_alu_op    [2:0]      ALU operation code
//   o_alu_src_b            1 = immediate operand on ALU input B
//   o_reg_dst              1 = rd is the destination (register-register ops)
// ----------------------------------------------------------------------------
module alu_op_decode
    import multicycle_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] i_op_q,
    output logic [2:0]      o_alu_op,
    output logic            o_alu_src_b,
    output logic            o_reg_dst
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        o_alu_op    = ALU_ADD;
        o_alu_src_b = 1'b0;
        o_reg_dst   = 1'b0;
        case (i_op_q)
            OP_W'(OP_ADD):  o_reg_dst = 1'b1;
            OP_W'(OP_SUB):  begin o_alu_op = ALU_SUB; o_reg_dst = 1'b1; end
            OP_W'(OP_ADDI): o_alu_src_b = 1'b1;
            OP_W'(OP_OR):   begin o_alu_op = ALU_OR;  o_reg_dst = 1'b1; end
            OP_W'(OP_AND):  begin o_alu_op = ALU_AND; o_reg_dst = 1'b1; end
            OP_W'(OP_ORI):  begin o_alu_op = ALU_OR;  o_alu_src_b = 1'b1; end
            // Shift amount comes from the shamt field, not the immediate path.
            OP_W'(OP_SLL):  begin o_alu_op = ALU_SLL; o_reg_dst = 1'b1; end
            OP_W'(OP_SLT):  begin o_alu_op = ALU_SLT; o_reg_dst = 1'b1; end
            OP_W'(OP_LW),
            OP_W'(OP_SW):   o_alu_src_b = 1'b1;
            OP_W'(OP_BEQ):  o_alu_op = ALU_SUB;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for a multi-cycle CPU: IF -> ID -> EXE_* -> MEM_* -> WB_*.
// Ports:
//   CLK                  rising-edge clock
//   Reset                synchronous, active-low reset
//   opcode [OP_W-1:0]    IR opcode, valid in ID
//   zero                 ALU zero flag, only consulted in EXE_B
//   ALUOp [2:0], ALUSrcB datapath ALU controls
//   PCWre, IRWre, RegWre, RegDst, mRD, mWR, DBDataSrc  control strobes
//   PCSrc [1:0]          next-PC selector
//   state [3:0]          current FSM state (debug), halted
// Build option: define MULTICYCLE_CTRL_JUMP_EN to decode j (111000) as a
// two-cycle jump; otherwise it is illegal and halts.
// While Reset is low every output is held at 0.
// ----------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic [2:0]      ALUOp,
    output logic            ALUSrcB,
    output logic            PCWre,
    output logic            IRWre,
    output logic            RegWre,
    output logic            RegDst,
    output logic            mRD,
    output logic            mWR,
    output logic            DBDataSrc,
    output logic [1:0]      PCSrc,
    output logic [3:0]      state,
    output logic            halted
);

    state_e          r_state;
    logic [OP_W-1:0] r_op_q;
    state_e          w_id_next;
    logic            w_id_jump;
    logic            w_datapath;
    logic [2:0]      w_dec_alu_op;
    logic            w_dec_alu_src_b;
    logic            w_dec_reg_dst;

    alu_op_decode #(.OP_W(OP_W)) u_alu_op_decode (
        .i_op_q      (r_op_q),
        .o_alu_op    (w_dec_alu_op),
        .o_alu_src_b (w_dec_alu_src_b),
        .o_reg_dst   (w_dec_reg_dst)
    );

    // Instruction class from the live opcode; only meaningful while in ID.
    always_comb begin
        w_id_next = S_HALT;
        w_id_jump = 1'b0;
        case (opcode)
            OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_ADDI), OP_W'(OP_OR),
            OP_W'(OP_AND), OP_W'(OP_ORI), OP_W'(OP_SLL), OP_W'(OP_SLT):
                w_id_next = S_EXE_R;
            OP_W'(OP_SW), OP_W'(OP_LW):
                w_id_next = S_EXE_LS;
            OP_W'(OP_BEQ):
                w_id_next = S_EXE_B;
`ifdef MULTICYCLE_CTRL_JUMP_EN
            OP_W'(OP_J): begin
                w_id_next = S_IF;
                w_id_jump = 1'b1;
            end
`endif
            default:
                w_id_next = S_HALT;
        endcase
    end

    // NOTE: non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state <= S_IF;
            r_op_q  <= '0;
        end else begin
            case (r_state)
                S_IF:     r_state <= S_ID;
                S_ID: begin
                    r_state <= w_id_next;
                    r_op_q  <= opcode;
                end
                S_EXE_R:  r_state <= S_WB_R;
                S_EXE_LS: begin
                    if (r_op_q == OP_W'(OP_LW)) r_state <= S_MEM_RD;
                    else                        r_state <= S_MEM_WR;
                end
                S_EXE_B:  r_state <= S_IF;
                S_MEM_RD: r_state <= S_WB_LD;
                S_MEM_WR: r_state <= S_IF;
                S_WB_R:   r_state <= S_IF;
                S_WB_LD:  r_state <= S_IF;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_IF;
            endcase
        end
    end

    // States in which the ALU is working on the latched instruction.
    assign w_datapath = r_state inside {S_EXE_R, S_EXE_LS, S_EXE_B, S_MEM_RD,
                                        S_MEM_WR, S_WB_R, S_WB_LD};

    // Moore decode of the registered state; zero only steers PCSrc in EXE_B.
    always_comb begin
        ALUOp     = ALU_ADD;
        ALUSrcB   = 1'b0;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        PCSrc     = PC_SEQ;
        state     = 4'd0;
        halted    = 1'b0;
        if (Reset) begin
            state  = r_state;
            halted = (r_state == S_HALT);
            if (w_datapath) begin
                ALUOp   = w_dec_alu_op;
                ALUSrcB = w_dec_alu_src_b;
            end
            case (r_state)
                S_IF: IRWre = 1'b1;
                S_ID: begin
                    if (w_id_jump) begin
                        PCWre = 1'b1;
                        PCSrc = PC_JUMP;
                    end
                end
                S_EXE_B: begin
                    PCWre = 1'b1;
                    PCSrc = zero ? PC_BRANCH : PC_SEQ;
                end
                S_MEM_RD: mRD = 1'b1;
                S_MEM_WR: begin
                    mWR   = 1'b1;
                    PCWre = 1'b1;
                end
                S_WB_R: begin
                    RegWre = 1'b1;
                    RegDst = w_dec_reg_dst;
                    PCWre  = 1'b1;
                end
                S_WB_LD: begin
                    RegWre    = 1'b1;
                    DBDataSrc = 1'b1;
                    PCWre     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl. Each check compares the full output
// bundle {state, ALUOp, ALUSrcB, PCWre, IRWre, RegWre, RegDst, mRD, mWR,
// DBDataSrc, PCSrc, halted} against hand-derived values.
// The enable argument "en" packs {PCWre, IRWre, RegWre, RegDst, mRD, mWR,
// DBDataSrc}. Honours MULTICYCLE_CTRL_JUMP_EN for the jump scenario.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;
    import multicycle_pkg::*;

    logic       CLK;
    logic       Reset;
    logic [5:0] opcode;
    logic       zero;
    logic [2:0] ALUOp;
    logic       ALUSrcB, PCWre, IRWre, RegWre, RegDst, mRD, mWR, DBDataSrc;
    logic [1:0] PCSrc;
    logic [3:0] state;
    logic       halted;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_ctrl #(.OP_W(6)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .opcode    (opcode),
        .zero      (zero),
        .ALUOp     (ALUOp),
        .ALUSrcB   (ALUSrcB),
        .PCWre     (PCWre),
        .IRWre     (IRWre),
        .RegWre    (RegWre),
        .RegDst    (RegDst),
        .mRD       (mRD),
        .mWR       (mWR),
        .DBDataSrc (DBDataSrc),
        .PCSrc     (PCSrc),
        .state     (state),
        .halted    (halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one clock edge and step off it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] st, input logic [2:0] alu,
                       input logic srcb, input logic [6:0] en, input logic [1:0] pcsrc,
                       input logic hlt);
        logic [17:0] obs;
        logic [17:0] exp;
        #1;
        obs = {state, ALUOp, ALUSrcB, PCWre, IRWre, RegWre, RegDst, mRD, mWR,
               DBDataSrc, PCSrc, halted};
        exp = {st, alu, srcb, en, pcsrc, hlt};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        Reset  = 1'b0;
        opcode = 6'b0;
        zero   = 1'b0;

        // Reset held low for two edges: everything forced to zero.
        chk("rst_comb", 4'd0, 3'b000, 1'b0, 7'b0000000, 2'b00, 1'b0);
        tick();
        tick();
        chk("rst_2cyc", 4'd0, 3'b000, 1'b0, 7'b0000000, 2'b00, 1'b0);

        // add: IF, ID, EXE_R, WB_R; live opcode changed after ID is ignored
        Reset  = 1'b1;
        opcode = OP_ADD;
        chk("add_if",   S_IF,    3'b000, 1'b0, 7'b0100000, 2'b00, 1'b0);
        tick();
        chk("add_id",   S_ID,    3'b000, 1'b0, 7'b0000000, 2'b00, 1'b0);
        tick();
        opcode = OP_LW;
        chk("add_exe",  S_EXE_R, 3'b000, 1'b0, 7'b0000000, 2'b00, 1'b0);
        tick();
        chk("add_wb",   S_WB_R,  3'b000, 1'b0, 7'b1011000, 2'b00, 1'b0);
        tick();

        // ori: ALUOp 101, immediate operand, RegDst 0
        opcode = OP_ORI;
        chk("ori_if",   S_IF,    3'b000, 1'b0, 7'b0100000, 2'b00, 1'b0);
        tick();
        tick();
        chk("ori_exe",  S_EXE_R, 3'b101, 1'b1, 7'b0000000, 2'b00, 1'b0);
        tick();
        chk("ori_wb",   S_WB_R,  3'b101, 1'b1, 7'b1010000, 2'b00, 1'b0);
        tick();

        // sll: ALUOp 100, shamt path so ALUSrcB 0
        opcode = OP_SLL;
        tick();
        tick();
        chk("sll_exe",  S_EXE_R, 3'b100, 1'b0, 7'b0000000, 2'b00, 1'b0);
        tick();
        chk("sll_wb",   S_WB_R,  3'b100, 1'b0, 7'b1011000, 2'b00, 1'b0);
        tick();

        // and / slt / sub operation codes
        opcode = OP_AND;
        tick();
        tick();
        chk("and_exe",  S_EXE_R, 3'b110, 1'b0, 7'b0000000, 2'b00, 1'b0);
        tick();
        tick();
        opcode = OP_SLT;
        tick();
        tick();
        chk("slt_exe",  S_EXE_R, 3'b010, 1'b0, 7'b0000000, 2'b00, 1'b0);
        tick();
        tick();
        opcode = OP_SUB;
        tick();
        tick();
        chk("sub_exe",  S_EXE_R, 3'b001, 1'b0, 7'b0000000, 2'b00, 1'b0);
        tick();
        chk("sub_wb",   S_WB_R,  3'b001, 1'b0, 7'b1011000, 2'b00, 1'b0);
        tick();

        // lw: 5 cycles
        opcode = OP_LW;
        chk("lw_if",    S_IF,     3'b000, 1'b0, 7'b0100000, 2'b00, 1'b0);
        tick();
        chk("lw_id",    S_ID,     3'b000, 1'b0, 7'b0000000, 2'b00, 1'b0);
        tick();
        opcode = OP_ADD;
        chk("lw_exe",   S_EXE_LS, 3'b000, 1'b1, 7'b0000000, 2'b00, 1'b0);
        tick();
        chk("lw_mem",   S_MEM_RD, 3'b000, 1'b1, 7'b0000100, 2'b00, 1'b0);
        tick();
        chk("lw_wb",    S_WB_LD,  3'b000, 1'b1, 7'b1010001, 2'b00, 1'b0);
        tick();
        chk("lw_done",  S_IF,     3'b000, 1'b0, 7'b0100000, 2'b00, 1'b0);

        // sw: 4 cycles
        opcode = OP_SW;
        tick();
        tick();
        chk("sw_exe",   S_EXE_LS, 3'b000, 1'b1, 7'b0000000, 2'b00, 1'b0);
        tick();
        chk("sw_mem",   S_MEM_WR, 3'b000, 1'b1, 7'b1000010, 2'b00, 1'b0);
        tick();
        chk("sw_done",  S_IF,     3'b000, 1'b0, 7'b0100000, 2'b00, 1'b0);

        // beq taken; zero has no effect in ID
        opcode = OP_BEQ;
        tick();
        zero = 1'b1;
        chk("beq_id_z", S_ID,    3'b000, 1'b0, 7'b0000000, 2'b00, 1'b0);
        tick();
        chk("beq_t",    S_EXE_B, 3'b001, 1'b0, 7'b1000000, 2'b01, 1'b0);
        tick();
        chk("beq_t_dn", S_IF,    3'b000, 1'b0, 7'b0100000, 2'b00, 1'b0);

        // beq not taken, then zero sampled combinationally within EXE_B
        zero = 1'b0;
        tick();
        tick();
        chk("beq_nt",   S_EXE_B, 3'b001, 1'b0, 7'b1000000, 2'b00, 1'b0);
        zero = 1'b1;
        chk("beq_comb", S_EXE_B, 3'b001, 1'b0, 7'b1000000, 2'b01, 1'b0);
        tick();
        zero = 1'b0;
        chk("beq_nt_dn", S_IF,   3'b000, 1'b0, 7'b0100000, 2'b00, 1'b0);

        // Reset asserted during MEM_WR of a sw
        opcode = OP_SW;
        tick();
        tick();
        tick();
        chk("rsw_mem",  S_MEM_WR, 3'b000, 1'b1, 7'b1000010, 2'b00, 1'b0);
        Reset = 1'b0;
        chk("rsw_drop", 4'd0,     3'b000, 1'b0, 7'b0000000, 2'b00, 1'b0);
        tick();
        chk("rsw_edge", 4'd0,     3'b000, 1'b0, 7'b0000000, 2'b00, 1'b0);
        Reset = 1'b1;
        chk("rsw_if",   S_IF,     3'b000, 1'b0, 7'b0100000, 2'b00, 1'b0);

        // Illegal opcode 101010 halts; stays halted 10 cycles
        opcode = 6'b101010;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            opcode = OP_ADD;
            chk($sformatf("halt_%0d", i), S_HALT, 3'b000, 1'b0, 7'b0000000, 2'b00, 1'b1);
        end
        Reset = 1'b0;
        chk("halt_rst", 4'd0, 3'b000, 1'b0, 7'b0000000, 2'b00, 1'b0);
        tick();
        Reset = 1'b1;
        chk("halt_if",  S_IF, 3'b000, 1'b0, 7'b0100000, 2'b00, 1'b0);

        // halt opcode
        opcode = OP_HALT;
        tick();
        tick();
        chk("hlt_op",   S_HALT, 3'b000, 1'b0, 7'b0000000, 2'b00, 1'b1);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        chk("hlt_if",   S_IF,   3'b000, 1'b0, 7'b0100000, 2'b00, 1'b0);

        // j (111000)
        opcode = OP_J;
        tick();
`ifdef MULTICYCLE_CTRL_JUMP_EN
        chk("j_id",     S_ID, 3'b000, 1'b0, 7'b1000000, 2'b10, 1'b0);
        tick();
        chk("j_done",   S_IF, 3'b000, 1'b0, 7'b0100000, 2'b00, 1'b0);
`else
        chk("j_id",     S_ID,   3'b000, 1'b0, 7'b0000000, 2'b00, 1'b0);
        tick();
        chk("j_halt",   S_HALT, 3'b000, 1'b0, 7'b0000000, 2'b00, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
